gpio_ctrl_rx: RTL and testbench

GPIO_CTRL_RX -- requirements
Module: gpio_ctrl_rx

---
 rtl/gpio_ctrl_rx.sv | 210 +++++++++++++++++++++
 tb/tb_gpio_ctrl_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_rx.sv
// gpio_ctrl_rx: decodes host GPIO words into kernel, image-memory, start and
// result-read strobes for a convolution engine.
//
// Ports:
//   i_clock, i_reset   single rising-edge clock, synchronous active-high reset
//   i_gpio_data[31:0]  host word: [31:29] ctrl, [28] valid, [24:1] data
//   o_gpio_data[31:0]  readback: [31] done, [30] err, [NB_OUT-1:0] result
//   o_led              copy of done
//   o_kernel_*         kernel row payload / row index / write strobe
//   o_img_len          latched image length (last address of a bank)
//   o_mem_*            image word payload / address / bank / write strobe
//   o_start            one-cycle convolution start
//   i_conv_done        convolution finished (level or pulse)
//   i_rd_data          result word at the consumer read pointer
//   o_rd_en            one-cycle advance of the result read pointer
//
// Build option: define GPIO_RX_SYNC_EN to put a two-flop synchronizer in front
// of the edge detector (strobe latency grows by one cycle).
module gpio_ctrl_rx #(
  parameter int NB_DATA = 24,
  parameter int NB_ADDR = 10,
  parameter int N_BANKS = 4,
  parameter int NB_OUT  = 13,
  localparam int NB_BANK = $clog2(N_BANKS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [31:0]        i_gpio_data,
  output logic [31:0]        o_gpio_data,
  output logic               o_led,
  output logic [NB_DATA-1:0] o_kernel_data,
  output logic [1:0]         o_kernel_row,
  output logic               o_kernel_we,
  output logic [NB_ADDR-1:0] o_img_len,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_BANK-1:0] o_mem_bank,
  output logic               o_mem_we,
  output logic               o_start,
  input  logic               i_conv_done,
  input  logic [NB_OUT-1:0]  i_rd_data,
  output logic               o_rd_en
);

  typedef enum logic {ST_FOLLOW, ST_RUN} state_t;

  localparam logic [2:0] C_KERNEL = 3'b000;
  localparam logic [2:0] C_LEN    = 3'b001;
  localparam logic [2:0] C_LOAD   = 3'b010;
  localparam logic [2:0] C_READ   = 3'b011;
  localparam logic [2:0] C_LAST   = 3'b100;

  logic [31:0] stage_in;

`ifdef GPIO_RX_SYNC_EN
  localparam int SYNC_DEPTH = 2;
  logic [31:0] sync_reg;
  always_ff @(posedge i_clock) begin
    if (i_reset) sync_reg <= '0;
    else         sync_reg <= i_gpio_data;
  end
  assign stage_in = sync_reg;
`else
  localparam int SYNC_DEPTH = 1;
  assign stage_in = i_gpio_data;
`endif

  logic [31:0]           gpio_reg;
  logic                  valid_prev_reg;
  logic [SYNC_DEPTH-1:0] live_sr;
  logic                  arm_reg;
  logic [2:0]            ctrl_prev_reg;
  state_t                state_reg;
  logic                  last_used_reg;
  logic [1:0]            row_reg;
  logic [NB_ADDR-1:0]    addr_reg;
  logic [NB_BANK-1:0]    bank_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  start_pend_reg;
  logic [NB_OUT-1:0]     rd_data_reg;

  logic [2:0]         ctrl;
  logic [23:0]        data;
  logic               v_event, follow_event, ctrl_changed, load_entry;
  logic [1:0]         row_eff;
  logic [NB_ADDR-1:0] addr_eff;
  logic [NB_BANK-1:0] bank_eff;
  logic               do_kernel, do_write, do_last, do_read, addr_wrap;

  // Reserved/unused host bits are sampled with the rest of the word.
  logic unused_bits;
  assign unused_bits = ^{gpio_reg[27:25], gpio_reg[0]};

  always_comb begin
    ctrl         = gpio_reg[31:29];
    data         = gpio_reg[24:1];
    // arm_reg keeps a valid that was already high across reset from
    // counting as a fresh rising edge.
    v_event      = arm_reg & gpio_reg[28] & ~valid_prev_reg;
    ctrl_changed = (ctrl != ctrl_prev_reg);
    // LAST -> LOAD keeps the address so a load sequence can be resumed.
    load_entry   = (ctrl == C_LOAD) && ctrl_changed && (ctrl_prev_reg != C_LAST);
    // Counters are cleared in the entry cycle, so an event in that same
    // cycle must already see the cleared value.
    row_eff      = ctrl_changed ? 2'd0 : row_reg;
    addr_eff     = load_entry ? '0 : addr_reg;
    bank_eff     = load_entry ? '0 : bank_reg;
    follow_event = v_event && (state_reg == ST_FOLLOW);
    do_kernel    = follow_event && (ctrl == C_KERNEL);
    do_last      = follow_event && (ctrl == C_LAST) && !(last_used_reg && !ctrl_changed);
    do_write     = (follow_event && (ctrl == C_LOAD)) || do_last;
    do_read      = follow_event && (ctrl == C_READ) && done_reg;
    addr_wrap    = (addr_eff == o_img_len);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      gpio_reg       <= '0;
      valid_prev_reg <= 1'b0;
      live_sr        <= '0;
      arm_reg        <= 1'b0;
      ctrl_prev_reg  <= C_KERNEL;
      state_reg      <= ST_FOLLOW;
      last_used_reg  <= 1'b0;
      row_reg        <= '0;
      addr_reg       <= '0;
      bank_reg       <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      start_pend_reg <= 1'b0;
      rd_data_reg    <= '0;
      o_kernel_data  <= '0;
      o_kernel_row   <= '0;
      o_kernel_we    <= 1'b0;
      o_img_len      <= '0;
      o_mem_data     <= '0;
      o_mem_addr     <= '0;
      o_mem_bank     <= '0;
      o_mem_we       <= 1'b0;
      o_start        <= 1'b0;
      o_rd_en        <= 1'b0;
    end else begin
      gpio_reg       <= stage_in;
      valid_prev_reg <= gpio_reg[28];
      // live_sr marks when gpio_reg holds real post-reset samples.
      live_sr        <= (live_sr << 1) | SYNC_DEPTH'(1);
      arm_reg        <= arm_reg | (live_sr[SYNC_DEPTH-1] & ~gpio_reg[28]);
      ctrl_prev_reg  <= ctrl;
      rd_data_reg    <= i_rd_data;

      o_kernel_we    <= 1'b0;
      o_mem_we       <= 1'b0;
      o_rd_en        <= 1'b0;
      o_start        <= start_pend_reg;
      start_pend_reg <= 1'b0;

      if (ctrl inside {3'b101, 3'b110, 3'b111}) err_reg <= 1'b1;
      if (ctrl == C_LEN) o_img_len <= data[NB_ADDR-1:0];

      if (ctrl_changed) begin
        last_used_reg <= 1'b0;
        if (ctrl == C_KERNEL || ctrl == C_LOAD) done_reg <= 1'b0;
        if (ctrl == C_KERNEL) row_reg <= '0;
      end
      if (load_entry) begin
        addr_reg <= '0;
        bank_reg <= '0;
      end

      if (do_kernel) begin
        o_kernel_data <= data[NB_DATA-1:0];
        o_kernel_row  <= row_eff;
        o_kernel_we   <= 1'b1;
        row_reg       <= (row_eff == 2'd2) ? 2'd0 : row_eff + 2'd1;
      end

      if (do_write) begin
        o_mem_data <= data[NB_DATA-1:0];
        o_mem_addr <= addr_eff;
        o_mem_bank <= bank_eff;
        o_mem_we   <= 1'b1;
        if (addr_wrap) begin
          addr_reg <= '0;
          bank_reg <= (bank_eff == NB_BANK'(N_BANKS - 1)) ? '0 : bank_eff + NB_BANK'(1);
        end else begin
          addr_reg <= addr_eff + NB_ADDR'(1);
        end
      end

      // Start follows the final write by one cycle.
      if (do_last) begin
        start_pend_reg <= 1'b1;
        last_used_reg  <= 1'b1;
        state_reg      <= ST_RUN;
      end

      if (do_read) o_rd_en <= 1'b1;

      if (state_reg == ST_RUN && i_conv_done) begin
        done_reg  <= 1'b1;
        state_reg <= ST_FOLLOW;
      end
    end
  end

  assign o_gpio_data = {done_reg, err_reg, {(30 - NB_OUT){1'b0}}, rd_data_reg};
  assign o_led       = done_reg;

endmodule

// File: tb/tb_gpio_ctrl_rx.sv
module tb_gpio_ctrl_rx;
  localparam int NB_DATA = 24;
  localparam int NB_ADDR = 10;
  localparam int N_BANKS = 4;
  localparam int NB_OUT  = 13;
  localparam int NB_BANK = 2;

  localparam logic [2:0] KERNEL = 3'b000;
  localparam logic [2:0] LEN    = 3'b001;
  localparam logic [2:0] LOAD   = 3'b010;
  localparam logic [2:0] READ   = 3'b011;
  localparam logic [2:0] LAST   = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_reset = 1'b1;
  logic [31:0]        i_gpio_data = '0;
  logic               i_conv_done = 1'b0;
  logic [NB_OUT-1:0]  i_rd_data = '0;
  logic [31:0]        o_gpio_data;
  logic               o_led;
  logic [NB_DATA-1:0] o_kernel_data;
  logic [1:0]         o_kernel_row;
  logic               o_kernel_we;
  logic [NB_ADDR-1:0] o_img_len;
  logic [NB_DATA-1:0] o_mem_data;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_BANK-1:0] o_mem_bank;
  logic               o_mem_we;
  logic               o_start;
  logic               o_rd_en;

  gpio_ctrl_rx #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_BANKS(N_BANKS), .NB_OUT(NB_OUT)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_gpio_data(i_gpio_data), .o_gpio_data(o_gpio_data),
    .o_led(o_led), .o_kernel_data(o_kernel_data), .o_kernel_row(o_kernel_row),
    .o_kernel_we(o_kernel_we), .o_img_len(o_img_len), .o_mem_data(o_mem_data),
    .o_mem_addr(o_mem_addr), .o_mem_bank(o_mem_bank), .o_mem_we(o_mem_we),
    .o_start(o_start), .i_conv_done(i_conv_done), .i_rd_data(i_rd_data), .o_rd_en(o_rd_en)
  );

  // Expected strobe: kind 0 kernel, 1 mem write, 2 read advance, 3 start.
  typedef struct {
    int kind;
    int data;
    int idx;
    int bank;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  logic [NB_OUT-1:0] rd_prev = '0;
  bit rd_chk = 0;
  bit rd_run = 0;
  int rd_cnt = 0;

  // Reference model state, kept in terms of the host-visible protocol.
  int   m_len, m_row, m_k;
  bit   m_done, m_err, m_run, m_last_used;
  logic [2:0] m_prev;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic take(input int kind, input int data, input int idx, input int bank);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d data 0x%0h idx %0d bank %0d, required none",
               kind, data, idx, bank);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.idx != idx || e.bank != bank) begin
        errors++;
        $display("FAIL strobe: got kind %0d data 0x%0h idx %0d bank %0d, required kind %0d data 0x%0h idx %0d bank %0d",
                 kind, data, idx, bank, e.kind, e.data, e.idx, e.bank);
      end else begin
        $display("ok   strobe kind %0d data 0x%0h idx %0d bank %0d", kind, data, idx, bank);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_prev <= i_rd_data;
  end

  // Monitor: every DUT strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_kernel_we) take(0, int'(o_kernel_data), int'(o_kernel_row), 0);
    if (o_mem_we) begin
      take(1, int'(o_mem_data), int'(o_mem_addr), int'(o_mem_bank));
      last_we_cyc = cyc;
    end
    if (o_rd_en) take(2, 0, 0, 0);
    if (o_start) begin
      take(3, 0, 0, 0);
      chk("start_after_we", cyc - last_we_cyc, 1);
    end
    if (rd_chk) chk("readback", o_gpio_data[12:0], rd_prev);
  end

  task automatic push(input int kind, input int data, input int idx, input int bank);
    exp_q.push_back('{kind, data, idx, bank});
  endtask

  task automatic model_ctrl(input logic [2:0] c);
    if (c != m_prev) begin
      m_last_used = 0;
      if (c == KERNEL) begin m_row = 0; m_done = 0; end
      if (c == LOAD) begin
        m_done = 0;
        if (m_prev != LAST) m_k = 0;
      end
    end
    if (c inside {3'b101, 3'b110, 3'b111}) m_err = 1;
    m_prev = c;
  endtask

  task automatic push_mem(input int d);
    push(1, d, m_k % (m_len + 1), (m_k / (m_len + 1)) % N_BANKS);
    m_k++;
  endtask

  task automatic model_event(input logic [2:0] c, input logic [23:0] d);
    model_ctrl(c);
    if (!m_run) begin
      case (c)
        KERNEL: begin push(0, int'(d), m_row, 0); m_row = (m_row + 1) % 3; end
        LOAD:   push_mem(int'(d));
        LAST:   if (!m_last_used) begin
                  push_mem(int'(d));
                  push(3, 0, 0, 0);
                  m_run = 1;
                  m_last_used = 1;
                end
        READ:   if (m_done) push(2, 0, 0, 0);
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic v, input logic [23:0] d);
    i_gpio_data = {c, v, 3'b000, d, 1'b0};
  endtask

  task automatic pulse(input logic [2:0] c, input logic [23:0] d, input int hold);
    @(negedge clk);
    drive(c, 1'b1, d);
    model_event(c, d);
    repeat (hold) @(negedge clk);
    drive(c, 1'b0, d);
    repeat (4) @(negedge clk);
  endtask

  task automatic set_len(input int len);
    @(negedge clk);
    drive(LEN, 1'b0, 24'(len));
    model_ctrl(LEN);
    m_len = len;
    repeat (3) @(negedge clk);
    chk("img_len", o_img_len, len);
  endtask

  task automatic conv_done();
    @(negedge clk);
    i_conv_done = 1'b1;
    @(negedge clk);
    i_conv_done = 1'b0;
    if (m_run) begin m_run = 0; m_done = 1; end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_status(input string name);
    chk({name, "_done"}, o_gpio_data[31], m_done);
    chk({name, "_err"}, o_gpio_data[30], m_err);
    chk({name, "_led"}, o_led, m_done);
    chk({name, "_zero"}, o_gpio_data[29:13], 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pending", exp_q.size(), 0);
    exp_q.delete();
    chk("rst_gpio", o_gpio_data, 0);
    chk("rst_led", o_led, 0);
    chk("rst_len", o_img_len, 0);
    chk("rst_kernel", {o_kernel_data, o_kernel_row}, 0);
    chk("rst_mem", {o_mem_data, o_mem_addr, o_mem_bank}, 0);
    chk("rst_strobes", {o_kernel_we, o_mem_we, o_start, o_rd_en}, 0);
    m_len = 0; m_row = 0; m_k = 0;
    m_done = 0; m_err = 0; m_run = 0; m_last_used = 0;
    m_prev = KERNEL;
    i_reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // READ while not done: ignored.
    pulse(READ, 24'h000123, 1);

    // Three kernel rows, then random rows wrapping the row counter.
    pulse(KERNEL, 24'h002000, 1);
    pulse(KERNEL, 24'h208020, 1);
    pulse(KERNEL, 24'h002000, 1);
    for (int i = 0; i < 5; i++) pulse(KERNEL, 24'($urandom), $urandom_range(1, 3));
    // Held valid produces a single strobe.
    pulse(KERNEL, 24'h00abcd, 10);

    // 16 words per bank, four banks, final word via LAST.
    set_len(15);
    for (int i = 0; i < 63; i++) pulse(LOAD, 24'($urandom), 1);
    pulse(LAST, 24'($urandom), 1);
    pulse(LAST, 24'h0000aa, 1);
    check_status("running");
    conv_done();
    check_status("done");
    pulse(LAST, 24'h0000bb, 1);

    // READ with done: counter on i_rd_data, readback one cycle late.
    rd_run = 1;
    @(negedge clk);
    rd_chk = 1;
    fork
      begin
        for (int i = 0; i < 26; i++) pulse(READ, 24'($urandom), 1);
        rd_run = 0;
      end
      begin
        while (rd_run) begin
          @(negedge clk);
          rd_cnt++;
          i_rd_data = NB_OUT'(rd_cnt);
        end
      end
    join
    rd_chk = 0;
    check_status("after_read");

    // Random lengths, including zero.
    for (int t = 0; t < 3; t++) begin
      set_len($urandom_range(0, 5));
      for (int i = 0; i < $urandom_range(3, 14); i++) pulse(LOAD, 24'($urandom), 1);
    end
    check_status("after_load");

    // Illegal control code.
    pulse(3'b111, 24'h00ffff, 1);
    check_status("illegal");
    pulse(KERNEL, 24'h123456, 1);
    check_status("illegal_sticky");

    // Reset in the middle of a load (next address 7), then reload.
    set_len(15);
    for (int i = 0; i < 7; i++) pulse(LOAD, 24'($urandom), 1);
    do_reset();
    for (int i = 0; i < 5; i++) pulse(LOAD, 24'($urandom), 1);
    check_status("final");

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
